// File: rtl/zl_rs_syndrome_pkg.sv
// Shared definitions for the RS(204,188) syndrome calculator over GF(2^8):
// code constants, symbol/counter types, the ACCUM/DUMP state encoding and
// the constant functions that build the root table at elaboration.
// Optional feature macro (used by zl_rs_syndrome): ZL_RS_SYNDROME_SHADOW_EN.
package zl_rs_syndrome_pkg;

    localparam int                   Gf_width   = 8;
    localparam logic [Gf_width-1:0]  Gf_poly    = 8'h1D;   // x^8 + x^4 + x^3 + x^2 + 1
    localparam int                   N          = 204;
    localparam int                   Nroots     = 16;
    localparam int                   First_root = 0;
    localparam logic [Gf_width-1:0]  Alpha      = 8'h02;

    localparam int Cnt_w = $clog2(N);
    localparam int Idx_w = $clog2(Nroots);

    typedef logic [Gf_width-1:0] sym_t;
    typedef logic [Cnt_w-1:0]    cnt_t;
    typedef logic [Idx_w-1:0]    idx_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    // Shift-and-add GF multiply; only used at elaboration to build constants.
    function automatic sym_t gf_mul_f(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < Gf_width; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = {sh[Gf_width-2:0], 1'b0} ^ (sh[Gf_width-1] ? Gf_poly : '0);
        end
        return acc;
    endfunction

    // alpha^e, evaluated at elaboration to produce each root_i.
    function automatic sym_t gf_pow(input sym_t alpha, input int e);
        sym_t r;
        r = sym_t'(1);
        for (int k = 0; k < e; k++) r = gf_mul_f(r, alpha);
        return r;
    endfunction

endpackage

// File: rtl/zl_rs_syndrome_if.sv
// Symbol-in / syndrome-out handshake bundle of the RS syndrome calculator.
// slave = the calculator, master = the codeword source / syndrome consumer.
interface zl_rs_syndrome_if;
    import zl_rs_syndrome_pkg::*;

    logic data_in_req;
    logic data_in_ack;
    sym_t data_in;

    logic synd_out_req;
    logic synd_out_ack;
    sym_t synd_out;
    idx_t synd_idx;
    logic synd_last;
    logic synd_err;

    modport slave (
        input  data_in_req, data_in, synd_out_ack,
        output data_in_ack, synd_out_req, synd_out, synd_idx, synd_last, synd_err
    );

    modport master (
        output data_in_req, data_in, synd_out_ack,
        input  data_in_ack, synd_out_req, synd_out, synd_idx, synd_last, synd_err
    );
endinterface

// File: rtl/zl_gf_mul.sv
// Combinational GF(2^Gf_width) multiplier, p = a * b mod (x^Gf_width + Gf_poly).
// With b tied to a constant the unused partial products fold away.
module zl_gf_mul #(
    parameter int                  Gf_width = 8,
    parameter logic [Gf_width-1:0] Gf_poly  = 8'h1D
) (
    input  logic [Gf_width-1:0] a,
    input  logic [Gf_width-1:0] b,
    output logic [Gf_width-1:0] p
);

    logic [Gf_width-1:0] sh;

    // Shift-and-add over the bits of b, reducing a*x^k on every step.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch);
        // blocking '=' here because each loop step reads the value the previous one wrote.
        p  = '0;
        sh = a;
        for (int k = 0; k < Gf_width; k++) begin
            if (b[k]) p = p ^ sh;
            sh = {sh[Gf_width-2:0], 1'b0} ^ (sh[Gf_width-1] ? Gf_poly : '0);
        end
    end

endmodule

// File: rtl/zl_rs_syndrome.sv
// RS(204,188) receive-side syndrome calculator. Symbols arrive highest degree
// first; all Nroots syndromes are accumulated in parallel by Horner's rule and
// then streamed out serially with an error flag on the last one.
// Optional feature macro: ZL_RS_SYNDROME_SHADOW_EN -- copies finished syndromes
// into a shadow bank so the next codeword can accumulate during the dump.
module zl_rs_syndrome
    import zl_rs_syndrome_pkg::*;
(
    input logic               clk,
    input logic               rst,
    zl_rs_syndrome_if.slave   bus
);

    state_t state_q;
    cnt_t   cnt_q;
    idx_t   idx_q;
    idx_t   idx_nxt;
    sym_t   s_q   [Nroots];
    sym_t   s_mul [Nroots];
    sym_t   s_nxt [Nroots];
    logic   nxt_err;
    sym_t   dump_sym;

    logic   out_req_q;
    sym_t   out_q;
    logic   last_q;
    logic   err_q;

    logic   accept;
    logic   last_sym;
    logic   out_ack;

    assign accept   = bus.data_in_req && bus.data_in_ack;
    assign last_sym = accept && (cnt_q == cnt_t'(N - 1));
    assign out_ack  = out_req_q && bus.synd_out_ack;
    assign idx_nxt  = idx_q + idx_t'(1);

    assign bus.synd_out_req = out_req_q;
    assign bus.synd_out     = out_q;
    assign bus.synd_idx     = idx_q;
    assign bus.synd_last    = last_q;
    assign bus.synd_err     = err_q;

    // One constant multiplier per root: s_mul[i] = S_i * alpha^(First_root+i).
    for (genvar g = 0; g < Nroots; g++) begin : g_root
        localparam sym_t Root = gf_pow(Alpha, First_root + g);
        zl_gf_mul #(
            .Gf_width (Gf_width),
            .Gf_poly  (Gf_poly)
        ) u_mul (
            .a (s_q[g]),
            .b (Root),
            .p (s_mul[g])
        );
    end

    // Next Horner step for every syndrome, restarting on the first symbol, plus the error flag.
    always_comb begin
        nxt_err = 1'b0;
        for (int i = 0; i < Nroots; i++) begin
            s_nxt[i] = ((cnt_q == '0) ? '0 : s_mul[i]) ^ bus.data_in;
            nxt_err  = nxt_err | (|s_nxt[i]);
        end
    end

    // Accumulators and symbol counter advance only on accepted symbols.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            // NOTE: the accumulator array is cleared on reset so an aborted word leaves nothing behind.
            for (int i = 0; i < Nroots; i++) s_q[i] <= '0;
        end else if (accept) begin
            cnt_q <= last_sym ? '0 : cnt_q + cnt_t'(1);
            for (int i = 0; i < Nroots; i++) s_q[i] <= s_nxt[i];
        end
    end

`ifdef ZL_RS_SYNDROME_SHADOW_EN
    sym_t sh_q [Nroots];

    // Snapshot the finished syndromes when a codeword completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Nroots; i++) sh_q[i] <= '0;
        end else if (last_sym) begin
            for (int i = 0; i < Nroots; i++) sh_q[i] <= s_nxt[i];
        end
    end

    // Keep accepting during the dump, except a completing symbol that would overwrite an unfinished dump.
    assign bus.data_in_ack = !((state_q == DUMP) && (cnt_q == cnt_t'(N - 1)));
    assign dump_sym        = sh_q[idx_nxt];
`else
    // No second bank: input is blocked until the dump has drained the accumulators.
    assign bus.data_in_ack = (state_q == ACCUM);
    assign dump_sym        = s_q[idx_nxt];
`endif

    // ACCUM/DUMP control with registered syndrome outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            idx_q     <= '0;
            out_req_q <= 1'b0;
            out_q     <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' so every register here sees the pre-edge values of the others.
            case (state_q)
                ACCUM: begin
                    if (last_sym) begin
                        state_q   <= DUMP;
                        out_req_q <= 1'b1;
                        idx_q     <= '0;
                        out_q     <= s_nxt[0];
                        last_q    <= (Nroots == 1);
                        err_q     <= nxt_err;
                    end
                end
                DUMP: begin
                    if (out_ack) begin
                        if (last_q) begin
                            state_q   <= ACCUM;
                            out_req_q <= 1'b0;
                            last_q    <= 1'b0;
                        end else begin
                            idx_q  <= idx_nxt;
                            out_q  <= dump_sym;
                            last_q <= (idx_nxt == idx_t'(Nroots - 1));
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_zl_rs_syndrome.sv
// Scoreboard bench for zl_rs_syndrome: the stimulus process pushes expected
// syndromes per codeword, the monitor pops and compares each presented syndrome.
module tb_zl_rs_syndrome;
    import zl_rs_syndrome_pkg::*;

    typedef struct {
        logic [7:0] synd;
        logic [3:0] idx;
        logic       last;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    zl_rs_syndrome_if bus();

    zl_rs_syndrome dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    logic [7:0] cw [N];
    logic [7:0] gpoly [17];
    logic [7:0] exp_s [16];

    // alpha^i, i = 0..15, worked out by hand for poly 0x11D.
    logic [7:0] alpha_pow [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};

    bit         stall_arm  = 0;
    logic [3:0] stall_idx  = 4'd0;
    int         stall_left = 0;
    logic [7:0] held_out;
    logic [3:0] held_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out, got no progress, expected completion", name);
    endtask

    // MSB-first GF multiply, for building the generator polynomial.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
            if (b[k]) r = r ^ a;
        end
        return r;
    endfunction

    // g(x) = prod (x + alpha^i); gpoly[k] is the coefficient of x^k.
    task automatic build_gpoly();
        logic [7:0] nw [17];
        for (int k = 0; k < 17; k++) gpoly[k] = 8'h00;
        gpoly[0] = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 17; k++)
                nw[k] = tb_gmul(gpoly[k], alpha_pow[i]) ^ ((k > 0) ? gpoly[k-1] : 8'h00);
            for (int k = 0; k < 17; k++) gpoly[k] = nw[k];
        end
    endtask

    task automatic clear_cw();
        for (int j = 0; j < N; j++) cw[j] = 8'h00;
    endtask

    // Codeword g(x) itself: symbol j carries the coefficient of x^(N-1-j).
    task automatic load_gword();
        clear_cw();
        for (int k = 0; k < 17; k++) cw[N-1-k] = gpoly[k];
    endtask

    task automatic push_exp(input logic err);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.synd = exp_s[i];
            e.idx  = 4'(i);
            e.last = (i == 15);
            e.err  = err;
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_exp(input logic [7:0] v);
        for (int i = 0; i < 16; i++) exp_s[i] = v;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_sym(input logic [7:0] d, inout bit stalled);
        int guard;
        guard = 0;
        bus.data_in_req = 1'b1;
        bus.data_in     = d;
        while (!bus.data_in_ack) begin
            @(negedge clk);
            stalled = 1;
            guard++;
            if (guard > 2000) begin
                timeout("data_in_ack");
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(inout bit stalled);
        for (int j = 0; j < N; j++) send_sym(cw[j], stalled);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        bus.data_in_req = 1'b0;
        while (exp_q.size() != 0 || bus.synd_out_req) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                timeout(name);
                exp_q.delete();
                break;
            end
        end
    endtask

    // Monitor: consume syndromes, compare against the scoreboard, optionally stall once.
    initial begin
        exp_t e;
        bus.synd_out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.synd_out_ack = 1'b0;
                stall_left = 0;
            end else if (bus.synd_out_req) begin
                if (stall_arm && bus.synd_idx == stall_idx) begin
                    stall_arm  = 0;
                    stall_left = 4;
                    held_out   = bus.synd_out;
                    held_idx   = bus.synd_idx;
                    bus.synd_out_ack = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                    check("stall_synd_out", bus.synd_out, held_out);
                    check("stall_synd_idx", bus.synd_idx, held_idx);
`ifndef ZL_RS_SYNDROME_SHADOW_EN
                    check("stall_data_in_ack", bus.data_in_ack, 1'b0);
`endif
                    bus.synd_out_ack = 1'b0;
                end else begin
                    bus.synd_out_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_output: got idx %0d synd %0h, expected no output",
                                 bus.synd_idx, bus.synd_out);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("synd_out[%0d]", e.idx), bus.synd_out, e.synd);
                        check($sformatf("synd_idx[%0d]", e.idx), bus.synd_idx, e.idx);
                        check($sformatf("synd_last[%0d]", e.idx), bus.synd_last, e.last);
                        if (e.last) check("synd_err", bus.synd_err, e.err);
                    end
                end
            end else begin
                bus.synd_out_ack = 1'b0;
            end
        end
    end

    // Stimulus.
    initial begin
        bit st;
        bit dummy;
        rst = 1'b1;
        bus.data_in_req = 1'b0;
        bus.data_in     = 8'h00;
        build_gpoly();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_synd_out_req", bus.synd_out_req, 1'b0);
        check("rst_synd_out", bus.synd_out, 8'h00);
        check("rst_synd_idx", bus.synd_idx, 4'd0);
        check("rst_synd_last", bus.synd_last, 1'b0);
        check("rst_synd_err", bus.synd_err, 1'b0);
        check("rst_data_in_ack", bus.data_in_ack, 1'b1);

        // All-zero codeword.
        dummy = 0;
        clear_cw();
        fill_exp(8'h00);
        push_exp(1'b0);
        send_word(dummy);
        drain("zero_word");

        // Valid codeword g(x).
        load_gword();
        fill_exp(8'h00);
        push_exp(1'b0);
        send_word(dummy);
        drain("g_word");

        // Zero word with last symbol 0x5A.
        clear_cw();
        cw[N-1] = 8'h5A;
        fill_exp(8'h5A);
        push_exp(1'b1);
        send_word(dummy);
        drain("last_5a_word");

        // Single 0x01 at degree 1 on top of g(x): S_i = alpha^i; stall 5 cycles at idx 3.
        load_gword();
        cw[N-2] = cw[N-2] ^ 8'h01;
        for (int i = 0; i < 16; i++) exp_s[i] = alpha_pow[i];
        push_exp(1'b1);
        stall_idx = 4'd3;
        stall_arm = 1;
        send_word(dummy);
        drain("stall_word");
        check("stall_consumed", stall_arm, 1'b0);

        // Reset after 100 symbols of a nonzero word, then a clean valid codeword.
        for (int j = 0; j < 100; j++) send_sym(8'hFF, dummy);
        bus.data_in_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_synd_out_req", bus.synd_out_req, 1'b0);
        check("midrst_data_in_ack", bus.data_in_ack, 1'b1);
        load_gword();
        fill_exp(8'h00);
        push_exp(1'b0);
        send_word(dummy);
        drain("after_reset_word");

        // Back-to-back words with data_in_req held high.
        st = 0;
        clear_cw();
        cw[N-2] = 8'h01;
        for (int i = 0; i < 16; i++) exp_s[i] = alpha_pow[i];
        push_exp(1'b1);
        send_word(st);
        clear_cw();
        cw[N-1] = 8'h5A;
        fill_exp(8'h5A);
        push_exp(1'b1);
        send_word(st);
        drain("b2b_words");
`ifdef ZL_RS_SYNDROME_SHADOW_EN
        check("b2b_no_input_stall", st, 1'b0);
`else
        check("b2b_input_stalled", st, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
